// File: rtl/mem_ctrl.sv
// mem_ctrl: sole owner of the byte-wide external memory port.
// Round-robin arbitration between instruction fetch and the load/store buffer,
// little-endian byte sequencing, pause/rollback handling and I/O back-pressure.
module mem_ctrl #(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rollback_in,

    input  logic                  if_valid_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,

    input  logic                  lsb_valid_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_done_out,
    output logic [31:0]           lsb_data_out,

    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t                state, state_n;
    logic                  owner_lsb, owner_lsb_n;
    logic                  last_lsb, last_lsb_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [CNT_W-1:0]      len, len_n;
    logic [31:0]           wdata, wdata_n;
    logic [31:0]           rdata, rdata_n;
    logic [7:0]            skid, skid_n;
    logic                  paused;
    logic                  wr_q, wr_n;
    logic [ADDR_WIDTH-1:0] mem_a_n;
    logic [7:0]            mem_dout_n;
    logic                  if_done_n, lsb_done_n;
    logic [31:0]           if_data_n, lsb_data_n;

    logic                  req_ok;
    logic                  grant_lsb;
    logic [7:0]            rbyte;
    logic [31:0]           rdata_cap;
    logic [CNT_W-1:0]      cnt_inc;
    logic [1:0]            rd_idx;
    logic [1:0]            wr_idx;

    // Transfer length in bytes for an LSB size code (11 treated as word).
    function automatic logic [CNT_W-1:0] size_len(input logic [1:0] size);
        case (size)
            2'b00:   return CNT_W'(1);
            2'b01:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

    // Writes are gated while paused; the registered strobe is replayed on resume.
    assign mem_wr = wr_q & rdy_in;

    // The byte lost at the first paused edge is kept in skid and used on resume.
    assign rbyte     = paused ? skid : mem_din;
    assign cnt_inc   = cnt + CNT_W'(1);
    assign rd_idx    = 2'(cnt - CNT_W'(1));
    assign wr_idx    = 2'(cnt_inc);
    assign rdata_cap = rdata | (32'(rbyte) << {rd_idx, 3'b000});
    assign req_ok    = rdy_in & ~rollback_in & ~if_done_out & ~lsb_done_out
                     & (if_valid_in | lsb_valid_in);
    assign grant_lsb = lsb_valid_in & (~if_valid_in | ~last_lsb);

    // State and datapath register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            owner_lsb    <= 1'b0;
            last_lsb     <= 1'b0;
            cnt          <= '0;
            len          <= '0;
            wdata        <= '0;
            rdata        <= '0;
            skid         <= '0;
            paused       <= 1'b0;
            wr_q         <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= '0;
            if_done_out  <= 1'b0;
            if_data_out  <= '0;
            lsb_done_out <= 1'b0;
            lsb_data_out <= '0;
        end else begin
            state        <= state_n;
            owner_lsb    <= owner_lsb_n;
            last_lsb     <= last_lsb_n;
            cnt          <= cnt_n;
            len          <= len_n;
            wdata        <= wdata_n;
            rdata        <= rdata_n;
            skid         <= skid_n;
            paused       <= ~rdy_in;
            wr_q         <= wr_n;
            mem_a        <= mem_a_n;
            mem_dout     <= mem_dout_n;
            if_done_out  <= if_done_n;
            if_data_out  <= if_data_n;
            lsb_done_out <= lsb_done_n;
            lsb_data_out <= lsb_data_n;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_n     = state;
        owner_lsb_n = owner_lsb;
        last_lsb_n  = last_lsb;
        cnt_n       = cnt;
        len_n       = len;
        wdata_n     = wdata;
        rdata_n     = rdata;
        skid_n      = skid;
        wr_n        = 1'b0;
        mem_a_n     = mem_a;
        mem_dout_n  = mem_dout;
        if_done_n   = 1'b0;
        if_data_n   = if_data_out;
        lsb_done_n  = 1'b0;
        lsb_data_n  = lsb_data_out;

        if (!rdy_in) begin
            wr_n = wr_q;
            if (!paused) begin
                skid_n = mem_din;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        owner_lsb_n = grant_lsb;
                        last_lsb_n  = grant_lsb;
                        cnt_n       = '0;
                        rdata_n     = '0;
                        if (grant_lsb) begin
                            mem_a_n = lsb_addr_in;
                            len_n   = size_len(lsb_size_in);
                            wdata_n = lsb_data_in;
                            if (lsb_wr_in) begin
                                mem_dout_n = lsb_data_in[7:0];
                                if ((lsb_addr_in >= IO_ADDR_BASE) && io_buffer_full) begin
                                    state_n = IO_WAIT;
                                end else begin
                                    state_n = WRITE;
                                    wr_n    = 1'b1;
                                end
                            end else begin
                                state_n = READ;
                            end
                        end else begin
                            mem_a_n = if_addr_in;
                            len_n   = CNT_W'(4);
                            state_n = READ;
                        end
                    end
                end

                READ: begin
                    if (rollback_in) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc < len) begin
                            mem_a_n = mem_a + ADDR_WIDTH'(1);
                        end
                        if (cnt != '0) begin
                            rdata_n = rdata_cap;
                        end
                        if (cnt == len) begin
                            state_n = IDLE;
                            if (owner_lsb) begin
                                lsb_done_n = 1'b1;
                                lsb_data_n = rdata_cap;
                            end else begin
                                if_done_n = 1'b1;
                                if_data_n = rdata_cap;
                            end
                        end
                    end
                end

                WRITE: begin
                    cnt_n = cnt_inc;
                    if (cnt_inc < len) begin
                        mem_a_n    = mem_a + ADDR_WIDTH'(1);
                        mem_dout_n = 8'(wdata >> {wr_idx, 3'b000});
                        wr_n       = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        lsb_done_n = 1'b1;
                    end
                end

                IO_WAIT: begin
                    if (!io_buffer_full) begin
                        state_n = WRITE;
                        wr_n    = 1'b1;
                    end
                end

                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a synchronous-read byte memory.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rollback_in;
    logic        if_valid_in;
    logic [31:0] if_addr_in;
    logic        if_done_out;
    logic [31:0] if_data_out;
    logic        lsb_valid_in;
    logic        lsb_wr_in;
    logic [1:0]  lsb_size_in;
    logic [31:0] lsb_addr_in;
    logic [31:0] lsb_data_in;
    logic        lsb_done_out;
    logic [31:0] lsb_data_out;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  mem [0:262143];
    bit          loaded;
    int          nwr = 0;

    int          errors = 0;
    int          checks = 0;

    mem_ctrl #(.ADDR_WIDTH(32), .IO_ADDR_BASE(32'h30000)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rollback_in    (rollback_in),
        .if_valid_in    (if_valid_in),
        .if_addr_in     (if_addr_in),
        .if_done_out    (if_done_out),
        .if_data_out    (if_data_out),
        .lsb_valid_in   (lsb_valid_in),
        .lsb_wr_in      (lsb_wr_in),
        .lsb_size_in    (lsb_size_in),
        .lsb_addr_in    (lsb_addr_in),
        .lsb_data_in    (lsb_data_in),
        .lsb_done_out   (lsb_done_out),
        .lsb_data_out   (lsb_data_out),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // Byte memory: preload once, then synchronous read and write-on-edge.
    always @(posedge clk_in) begin
        if (!loaded) begin
            mem[18'h00100] <= 8'h13;
            mem[18'h00101] <= 8'h05;
            mem[18'h00102] <= 8'h00;
            mem[18'h00103] <= 8'h00;
            mem[18'h00104] <= 8'h93;
            mem[18'h00105] <= 8'h00;
            mem[18'h00106] <= 8'h10;
            mem[18'h00107] <= 8'h00;
            mem[18'h3FFFF] <= 8'h5A;
            mem[18'h00000] <= 8'hA5;
            mem[18'h02301] <= 8'h77;
            mem_din        <= 8'h00;
            loaded         <= 1'b1;
        end else begin
            mem_din <= mem[mem_a[17:0]];
            if (mem_wr) begin
                mem[mem_a[17:0]] <= mem_dout;
                nwr <= nwr + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for a done pulse; n = negedges waited (-1 on timeout).
    task automatic wait_done(input bit lsb, input int limit, output int n, output logic [31:0] d);
        n = 0;
        d = '0;
        repeat (limit) begin
            @(negedge clk_in);
            n++;
            if (lsb ? lsb_done_out : if_done_out) begin
                d = lsb ? lsb_data_out : if_data_out;
                return;
            end
        end
        n = -1;
    endtask

    // Issue one LSB request after an idle cycle; returns just after the accept edge.
    task automatic lsb_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] data);
        @(negedge clk_in);
        lsb_valid_in = 1'b1;
        lsb_wr_in    = wr;
        lsb_size_in  = size;
        lsb_addr_in  = addr;
        lsb_data_in  = data;
        @(negedge clk_in);
        lsb_valid_in = 1'b0;
    endtask

    task automatic if_req(input logic [31:0] addr);
        @(negedge clk_in);
        if_valid_in = 1'b1;
        if_addr_in  = addr;
        @(negedge clk_in);
        if_valid_in = 1'b0;
    endtask

    initial begin
        int          n;
        int          nwr0;
        int          ndone;
        int          at_c [4];
        logic [31:0] dat [4];
        logic [3:0]  order;
        logic [31:0] d;
        bit          seen;

        rst_in = 1'b1; rdy_in = 1'b1; rollback_in = 1'b0;
        if_valid_in = 1'b0; if_addr_in = '0;
        lsb_valid_in = 1'b0; lsb_wr_in = 1'b0; lsb_size_in = '0;
        lsb_addr_in = '0; lsb_data_in = '0; io_buffer_full = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset state
        check("rst_mem_wr",   32'(mem_wr), 32'd0);
        check("rst_mem_a",    mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        check("rst_dones",    32'({if_done_out, lsb_done_out}), 32'd0);
        check("rst_if_data",  if_data_out, 32'd0);
        check("rst_lsb_data", lsb_data_out, 32'd0);
        rst_in = 1'b0;

        // Word fetch from 0x100
        if_req(32'h100);
        check("fetch_a0", mem_a, 32'h100);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk_in);
            check("fetch_a_step", mem_a, 32'h100 + 32'(k));
        end
        wait_done(1'b0, 10, n, d);
        check("fetch_latency", 32'(n + 3), 32'd5);
        check("fetch_data", d, 32'h0000_0513);

        // Half store then half load at 0x2000
        lsb_req(1'b1, 2'b01, 32'h2000, 32'h0000_BEEF);
        check("st_wr0", 32'(mem_wr), 32'd1);
        check("st_a0", mem_a, 32'h2000);
        check("st_d0", 32'(mem_dout), 32'hEF);
        @(negedge clk_in);
        check("st_wr1", 32'(mem_wr), 32'd1);
        check("st_a1", mem_a, 32'h2001);
        check("st_d1", 32'(mem_dout), 32'hBE);
        check("st_nodone1", 32'(lsb_done_out), 32'd0);
        @(negedge clk_in);
        check("st_done", 32'(lsb_done_out), 32'd1);
        check("st_wr_off", 32'(mem_wr), 32'd0);
        check("st_mem", 32'({mem[18'h2001], mem[18'h2000]}), 32'hBEEF);
        lsb_req(1'b0, 2'b01, 32'h2000, 32'h0);
        wait_done(1'b1, 10, n, d);
        check("ld_latency", 32'(n), 32'd3);
        check("ld_data", d, 32'h0000_BEEF);

        // Contention from reset: LSB byte load vs fetch, both held valid
        @(negedge clk_in);
        rst_in = 1'b1;
        if_valid_in = 1'b1; if_addr_in = 32'h100;
        lsb_valid_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'b00; lsb_addr_in = 32'h2000;
        @(negedge clk_in);
        rst_in = 1'b0;
        ndone = 0; order = '0;
        for (int i = 0; i < 4; i++) begin
            at_c[i] = -1;
            dat[i]  = '0;
        end
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge clk_in);
            if (lsb_done_out || if_done_out) begin
                order       = {order[2:0], lsb_done_out};
                at_c[ndone] = c;
                dat[ndone]  = lsb_done_out ? lsb_data_out : if_data_out;
                ndone++;
            end
        end
        if_valid_in = 1'b0; lsb_valid_in = 1'b0;
        check("rr_count", 32'(ndone), 32'd4);
        check("rr_order", 32'(order), 32'b1010);
        check("rr_at0", 32'(at_c[0]), 32'd2);
        check("rr_at1", 32'(at_c[1]), 32'd9);
        check("rr_at2", 32'(at_c[2]), 32'd13);
        check("rr_at3", 32'(at_c[3]), 32'd20);
        check("rr_lsb_data", dat[0], 32'h0000_00EF);
        check("rr_if_data", dat[1], 32'h0000_0513);

        // I/O store under back-pressure
        io_buffer_full = 1'b1;
        lsb_req(1'b1, 2'b00, 32'h30000, 32'h41);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk_in);
            if (mem_wr) seen = 1'b1;
        end
        check("io_hold", 32'(seen), 32'd0);
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_wr", 32'(mem_wr), 32'd1);
        check("io_dout", 32'(mem_dout), 32'h41);
        check("io_a", mem_a, 32'h30000);
        @(negedge clk_in);
        check("io_done", 32'(lsb_done_out), 32'd1);
        check("io_mem", 32'(mem[18'h30000]), 32'h41);

        // Rollback two cycles into a fetch; the next fetch is accepted at once
        if_req(32'h100);
        @(negedge clk_in);
        rollback_in = 1'b1;
        @(negedge clk_in);
        rollback_in = 1'b0;
        check("rb_no_done", 32'(if_done_out), 32'd0);
        if_valid_in = 1'b1; if_addr_in = 32'h104;
        @(negedge clk_in);
        if_valid_in = 1'b0;
        check("rb_refetch_a", mem_a, 32'h104);
        wait_done(1'b0, 10, n, d);
        check("rb_refetch_lat", 32'(n), 32'd5);
        check("rb_refetch_data", d, 32'h0010_0093);

        // Rollback during a word store does not abort it
        lsb_req(1'b1, 2'b10, 32'h2100, 32'hDEAD_BEEF);
        rollback_in = 1'b1;
        wait_done(1'b1, 10, n, d);
        rollback_in = 1'b0;
        check("rbst_latency", 32'(n), 32'd4);
        check("rbst_mem", {mem[18'h2103], mem[18'h2102], mem[18'h2101], mem[18'h2100]},
              32'hDEAD_BEEF);

        // Word load, unpaused reference
        lsb_req(1'b0, 2'b10, 32'h2100, 32'h0);
        wait_done(1'b1, 10, n, d);
        check("ldw_latency", 32'(n), 32'd5);
        check("ldw_data", d, 32'hDEAD_BEEF);

        // Same load with a 3-cycle pause mid-transfer
        lsb_req(1'b0, 2'b10, 32'h2100, 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        check("pld_a_before", mem_a, 32'h2102);
        rdy_in = 1'b0;
        @(negedge clk_in);
        check("pld_a_hold", mem_a, 32'h2102);
        @(negedge clk_in);
        @(negedge clk_in);
        check("pld_a_hold_end", mem_a, 32'h2102);
        check("pld_no_done", 32'(lsb_done_out), 32'd0);
        rdy_in = 1'b1;
        wait_done(1'b1, 20, n, d);
        check("pld_latency", 32'(n + 5), 32'd8);
        check("pld_data", d, 32'hDEAD_BEEF);

        // Word store with a 2-cycle pause: each byte written exactly once
        nwr0 = nwr;
        lsb_req(1'b1, 2'b10, 32'h2200, 32'h1122_3344);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #1;
        check("pst_wr_forced", 32'(mem_wr), 32'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b1;
        wait_done(1'b1, 20, n, d);
        check("pst_latency", 32'(n + 3), 32'd6);
        check("pst_nwrites", 32'(nwr - nwr0), 32'd4);
        check("pst_mem", {mem[18'h2203], mem[18'h2202], mem[18'h2201], mem[18'h2200]},
              32'h1122_3344);

        // Half load across the address wrap
        lsb_req(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
        check("wrap_a0", mem_a, 32'hFFFF_FFFF);
        @(negedge clk_in);
        check("wrap_a1", mem_a, 32'h0);
        wait_done(1'b1, 10, n, d);
        check("wrap_latency", 32'(n + 1), 32'd3);
        check("wrap_data", d, 32'h0000_A55A);

        // Reset in the middle of a word store
        lsb_req(1'b1, 2'b10, 32'h2300, 32'hCAFE_F00D);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("mrst_wr", 32'(mem_wr), 32'd0);
        check("mrst_a", mem_a, 32'd0);
        check("mrst_lsb_data", lsb_data_out, 32'd0);
        check("mrst_partial", 32'({mem[18'h2301], mem[18'h2300]}), 32'h770D);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("mrst_idle", 32'({mem_wr, lsb_done_out, if_done_out}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single owner of the CPU core's byte-wide external memory port.
- Arbitrates between two requesters: instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Sequences each request as a little-endian byte stream and returns assembled data with a one-cycle done pulse.
- Handles the rdy_in pause, branch-misprediction rollback, and I/O write back-pressure.

Parameters:
- ADDR_WIDTH, 32, width of every address port.
- IO_ADDR_BASE, 32'h30000, addresses >= this value are I/O space.

Ports:
- clk_in  input  1  core clock
- rst_in  input  1  asynchronous reset, active-high
- rdy_in  input  1  global ready; low = pause
- rollback_in  input  1  misprediction flush; aborts reads
- if_valid_in  input  1  fetch request pending
- if_addr_in  input  ADDR_WIDTH  fetch address
- if_done_out  output  1  one-cycle pulse, fetch data valid
- if_data_out  output  32  fetched word
- lsb_valid_in  input  1  LSB request pending
- lsb_wr_in  input  1  1 = store, 0 = load
- lsb_size_in  input  2  00 = byte, 01 = half, 10 = word (11 is illegal)
- lsb_addr_in  input  ADDR_WIDTH  LSB address
- lsb_data_in  input  32  store data; low bytes used
- lsb_done_out  output  1  one-cycle pulse, transaction complete
- lsb_data_out  output  32  load data, zero-extended
- mem_din  input  8  memory read byte
- mem_dout  output  8  memory write byte
- mem_a  output  ADDR_WIDTH  memory byte address
- mem_wr  output  1  1 = write this cycle
- io_buffer_full  input  1  I/O write FIFO full

Behaviour:
- Reset (async, rst_in=1):
  - All outputs are 0 and the state is IDLE.
  - last_grant = IF, so the LSB wins the first tie.
- Memory model: synchronous read. mem_din holds M[mem_a of the previous cycle]. A write occurs on the edge where mem_wr=1.
- States: IDLE, READ, WRITE, IO_WAIT.
- IDLE:
  - A request is sampled at edge E0 only when rdy_in=1, rollback_in=0, and neither done output is high this cycle.
  - Both valid: grant the requester not in last_grant (round robin). One valid: grant it.
  - Latch addr, size N (IF: 4; LSB: 1/2/4), write data and owner. Update last_grant.
- READ:
  - After E0, mem_a=A.
  - After E(k), mem_a=A+k for k<N. mem_a holds after the last byte is presented.
  - The byte for A+k is captured at E(k+2) into bits [8k+7:8k].
  - Done pulse and data appear after E(N+1). A word read therefore completes 5 edges after accept.
  - Unused upper bytes are 0.
- WRITE:
  - After E(k), k=0..N-1: mem_a=A+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - After E(N): mem_wr=0, lsb_done_out=1.
- IO write (A >= IO_ADDR_BASE):
  - If io_buffer_full=1 at grant or before any byte is issued, enter IO_WAIT with mem_wr=0.
  - Proceed to WRITE on the first edge where io_buffer_full=0.
  - I/O stores are single-byte; other sizes are illegal.
- Done pulse:
  - Exactly one cycle; the state is IDLE during it.
  - The data output holds its value until the next done for that owner.
- rdy_in=0:
  - State, byte counter and captured data are frozen; mem_wr is forced 0 and mem_a holds.
  - A write byte not issued is issued after resume.
  - A read byte is re-captured from the held mem_a after resume. No byte may be skipped or duplicated.
- rollback_in=1 (with rdy_in=1):
  - Any READ (IF or LSB) returns to IDLE at that edge with no done pulse.
  - No new grant occurs in that cycle.
  - WRITE and IO_WAIT are unaffected and complete normally; stores are committed by the time they are issued.
- Simultaneous done and new valid: no grant that cycle. Requesters drop valid on seeing done.
- Address arithmetic: A+k wraps modulo 2^ADDR_WIDTH.
- Reset mid-transaction:
  - Immediate IDLE with all outputs 0.
  - Partial writes already performed are not undone.

Test Plan:
- Fetch: M[0x100..0x103]=13 05 00 00, if_valid with addr 0x100 -> mem_a steps 0x100..0x103; if_data_out=0x00000513 with if_done_out high 5 edges after accept.
- Store then load: lsb_wr=1, size=01, addr 0x2000, data 0xBEEF -> 2 cycles mem_wr=1, bytes EF then BE, done after 2 edges. Then a load of size=01 -> lsb_data_out=0x0000BEEF.
- Contention: both valid continuously from reset -> grants alternate LSB, IF, LSB, IF; no request is starved.
- IO back-pressure: store byte 0x41 to 0x30000 with io_buffer_full=1 for 10 cycles -> mem_wr stays 0; mem_wr=1 with mem_dout=0x41 on the first cycle after full drops.
- Rollback: assert rollback_in 2 cycles into a fetch -> no if_done_out and IDLE next cycle. Rollback during a word store -> all 4 bytes are still written.
- Pause: drop rdy_in for 3 cycles mid word-read -> completion is delayed exactly 3 cycles and the data is identical to the unpaused run.
